// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch stage and the decode logic that the
// later hazard/writeback stages will reuse.
package isa_pkg;

  localparam int INSTR_W      = 9;
  localparam int IMM_FLAG_BIT = 8;

  localparam logic [3:0] OP_GET  = 4'b0000;
  localparam logic [3:0] OP_PUT  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_BT   = 4'b0111;
  localparam logic [3:0] OP_BF   = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_INC  = 4'b1011;
  localparam logic [3:0] OP_DEC  = 4'b1100;
  localparam logic [3:0] OP_NOT  = 4'b1101;
  localparam logic [3:0] OP_CMP  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational field decode of one instruction word. Immediate words
// (flag bit clear) decode to op 0 / reg 0 and never branch or halt.
module instr_decode
  import isa_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         op,
  output logic [3:0]         reg_sel,
  output logic               is_branch,
  output logic               is_halt
);

  logic is_reg_op;

  assign is_reg_op = instr[IMM_FLAG_BIT];
  assign op        = is_reg_op ? instr[3:0] : 4'b0000;
  assign reg_sel   = is_reg_op ? instr[7:4] : 4'b0000;
  assign is_branch = is_reg_op && ((instr[3:0] == OP_BT) || (instr[3:0] == OP_BF));
  assign is_halt   = is_reg_op && (instr[3:0] == OP_HALT);

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and instruction fetch FSM: request a word, wait for it,
// hold it for the execute stage until accepted, then advance or branch.
module fetch_sequencer
  import isa_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic               CLK,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  input  logic               ex_ready,
  input  logic [7:0]         alu_out,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_immediate,
  output logic [3:0]         instr_op,
  output logic [3:0]         reg_sel,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  fetch_state_t       state;
  logic [INSTR_W-1:0] instr_q;
  logic               is_branch;
  logic               is_halt;
  logic [PC_W-1:0]    branch_off;
  logic               branch_taken;

  instr_decode u_decode (
    .instr     (instr_q),
    .op        (instr_op),
    .reg_sel   (reg_sel),
    .is_branch (is_branch),
    .is_halt   (is_halt)
  );

  assign instr_immediate = instr_q;
  assign imem_addr       = pc;

  // alu_out is a signed offset; zero doubles as "condition false".
  assign branch_off   = PC_W'($signed(alu_out));
  assign branch_taken = is_branch && (alu_out != 8'd0);

  // NOTE: every register below uses <= so all updates see the pre-edge
  // values; the latched instruction word is reset too, so decode is defined.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= REQ;
      pc          <= '0;
      instr_q     <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          imem_req <= 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          imem_req <= 1'b0;
          if (imem_rvalid) begin
            instr_q     <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (ex_ready) begin
            instr_valid <= 1'b0;
            if (is_halt) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc    <= branch_taken ? pc + branch_off : pc + PC_W'(1);
              state <= REQ;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a scripted instruction memory and
// execute stage, with hand-computed expectations checked per scenario.
module tb_fetch_sequencer;

  localparam int PC_W = 10;

  logic            CLK;
  logic            reset_n;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_rdata;
  logic            imem_rvalid;
  logic            ex_ready;
  logic [7:0]      alu_out;
  logic            instr_valid;
  logic [8:0]      instr_immediate;
  logic [3:0]      instr_op;
  logic [3:0]      reg_sel;
  logic [PC_W-1:0] pc;
  logic            halted;

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(.PC_W(PC_W)) dut (
    .CLK             (CLK),
    .reset_n         (reset_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_rvalid     (imem_rvalid),
    .ex_ready        (ex_ready),
    .alu_out         (alu_out),
    .instr_valid     (instr_valid),
    .instr_immediate (instr_immediate),
    .instr_op        (instr_op),
    .reg_sel         (reg_sel),
    .pc              (pc),
    .halted          (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Waits (bounded) for a request; returns how many falling edges it took.
  task automatic wait_req(output bit ok, output logic [PC_W-1:0] addr, output int n);
    ok   = 1'b0;
    addr = '0;
    n    = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      n = i + 1;
      if (imem_req === 1'b1) begin
        ok   = 1'b1;
        addr = imem_addr;
      end
    end
  endtask

  task automatic mem_reply(input logic [8:0] word, input int lat);
    repeat (lat) @(negedge CLK);
    imem_rdata  = word;
    imem_rvalid = 1'b1;
    @(negedge CLK);
    imem_rvalid = 1'b0;
    imem_rdata  = 9'h1AA;
  endtask

  task automatic accept(input logic [7:0] alu);
    ex_ready = 1'b1;
    alu_out  = alu;
    @(negedge CLK);
    ex_ready = 1'b0;
    alu_out  = 8'h00;
  endtask

  task automatic run_instr(input logic [8:0] word, input logic [7:0] alu,
                           output bit ok, output logic [PC_W-1:0] addr);
    int n;
    wait_req(ok, addr, n);
    if (ok) begin
      mem_reply(word, 1);
      accept(alu);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset_n     = 1'b0;
    ex_ready    = 1'b0;
    imem_rvalid = 1'b0;
    alu_out     = 8'h00;
    @(negedge CLK);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_fetch();
    bit ok;
    logic [PC_W-1:0] addr;
    int n;
    @(negedge CLK);
    checks++;
    if ({pc, instr_valid, imem_req, halted, instr_immediate} !== {10'd0, 1'b0, 1'b0, 1'b0, 9'h000}) begin
      errors++;
      $display("FAIL reset_state: pc=%0d valid=%b req=%b halted=%b instr=%h, expected all zero",
               pc, instr_valid, imem_req, halted, instr_immediate);
    end
    reset_n = 1'b1;
    wait_req(ok, addr, n);
    checks++;
    if (!ok || addr !== 10'd0 || n != 1) begin
      errors++;
      $display("FAIL first_req: ok=%0d addr=%0d cycle=%0d, expected addr 0 at cycle 1", ok, addr, n);
    end
    @(negedge CLK);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL req_one_cycle: imem_req=%b expected 0", imem_req);
    end
    mem_reply(9'h124, 1);
    checks++;
    if ({instr_valid, instr_op, reg_sel, instr_immediate, pc} !== {1'b1, 4'b0100, 4'd2, 9'h124, 10'd0}) begin
      errors++;
      $display("FAIL add_issue: valid=%b op=%h reg=%0d instr=%h pc=%0d, expected 1 4 2 124 0",
               instr_valid, instr_op, reg_sel, instr_immediate, pc);
    end
    accept(8'h00);
    checks++;
    if (pc !== 10'd1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_accept: pc=%0d valid=%b, expected 1 0", pc, instr_valid);
    end
    wait_req(ok, addr, n);
    checks++;
    if (!ok || addr !== 10'd1) begin
      errors++;
      $display("FAIL second_req: ok=%0d addr=%0d, expected addr 1", ok, addr);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [PC_W-1:0] addr;
    int n;
    do_reset();
    wait_req(ok, addr, n);
    ex_ready = 1'b1;
    @(negedge CLK);
    ex_ready = 1'b0;
    checks++;
    if (!ok || pc !== 10'd0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL ex_ready_in_wait: ok=%0d pc=%0d valid=%b, expected pc 0 valid 0", ok, pc, instr_valid);
    end
    mem_reply(9'h03C, 1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({instr_valid, instr_immediate, instr_op, reg_sel, pc} !== {1'b1, 9'h03C, 4'd0, 4'd0, 10'd0}) begin
        errors++;
        $display("FAIL imm_stall_%0d: valid=%b instr=%h op=%h reg=%0d pc=%0d, expected 1 03c 0 0 0",
                 i, instr_valid, instr_immediate, instr_op, reg_sel, pc);
      end
      if (i < 4) @(negedge CLK);
    end
    accept(8'h55);
    checks++;
    if (pc !== 10'd1) begin
      errors++;
      $display("FAIL imm_accept: pc=%0d expected 1", pc);
    end
  endtask

  task automatic test_branch();
    bit ok;
    logic [PC_W-1:0] addr;
    do_reset();
    run_instr(9'h107, 8'h0A, ok, addr);
    checks++;
    if (!ok || pc !== 10'd10) begin
      errors++;
      $display("FAIL bt_forward: ok=%0d pc=%0d expected 10", ok, pc);
    end
    run_instr(9'h117, 8'hFB, ok, addr);
    checks++;
    if (!ok || addr !== 10'd10 || pc !== 10'd5) begin
      errors++;
      $display("FAIL bt_backward: ok=%0d addr=%0d pc=%0d, expected addr 10 pc 5", ok, addr, pc);
    end
    do_reset();
    run_instr(9'h107, 8'h0A, ok, addr);
    run_instr(9'h108, 8'h00, ok, addr);
    checks++;
    if (!ok || addr !== 10'd10 || pc !== 10'd11) begin
      errors++;
      $display("FAIL bf_not_taken: ok=%0d addr=%0d pc=%0d, expected addr 10 pc 11", ok, addr, pc);
    end
    run_instr(9'h0A7, 8'h20, ok, addr);
    checks++;
    if (!ok || pc !== 10'd12) begin
      errors++;
      $display("FAIL imm_no_branch: ok=%0d pc=%0d expected 12", ok, pc);
    end
    run_instr(9'h0FF, 8'h00, ok, addr);
    checks++;
    if (!ok || pc !== 10'd13 || halted !== 1'b0) begin
      errors++;
      $display("FAIL imm_no_halt: ok=%0d pc=%0d halted=%b, expected 13 0", ok, pc, halted);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [PC_W-1:0] addr;
    do_reset();
    run_instr(9'h107, 8'hFF, ok, addr);
    checks++;
    if (!ok || pc !== 10'd1023) begin
      errors++;
      $display("FAIL branch_to_top: ok=%0d pc=%0d expected 1023", ok, pc);
    end
    run_instr(9'h124, 8'h00, ok, addr);
    checks++;
    if (!ok || addr !== 10'd1023 || pc !== 10'd0) begin
      errors++;
      $display("FAIL pc_wrap: ok=%0d addr=%0d pc=%0d, expected addr 1023 pc 0", ok, addr, pc);
    end
    do_reset();
    run_instr(9'h107, 8'hFC, ok, addr);
    run_instr(9'h108, 8'h07, ok, addr);
    checks++;
    if (!ok || addr !== 10'd1020 || pc !== 10'd3) begin
      errors++;
      $display("FAIL branch_wrap: ok=%0d addr=%0d pc=%0d, expected addr 1020 pc 3", ok, addr, pc);
    end
  endtask

  task automatic test_halt();
    bit ok;
    logic [PC_W-1:0] addr;
    int n;
    int req_seen;
    int bad_seen;
    do_reset();
    run_instr(9'h124, 8'h00, ok, addr);
    wait_req(ok, addr, n);
    mem_reply(9'h10F, 1);
    checks++;
    if (!ok || instr_valid !== 1'b1 || instr_op !== 4'hF || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_issue: ok=%0d valid=%b op=%h halted=%b, expected 1 f 0", ok, instr_valid, instr_op, halted);
    end
    accept(8'h01);
    checks++;
    if ({halted, instr_valid, pc} !== {1'b1, 1'b0, 10'd1}) begin
      errors++;
      $display("FAIL halt_accept: halted=%b valid=%b pc=%0d, expected 1 0 1", halted, instr_valid, pc);
    end
    req_seen = 0;
    bad_seen = 0;
    for (int i = 0; i < 20; i++) begin
      imem_rvalid = (i % 2 == 0);
      imem_rdata  = 9'h124;
      ex_ready    = 1'b1;
      @(negedge CLK);
      if (imem_req !== 1'b0) req_seen++;
      if ({halted, instr_valid, pc} !== {1'b1, 1'b0, 10'd1}) bad_seen++;
    end
    imem_rvalid = 1'b0;
    ex_ready    = 1'b0;
    checks++;
    if (req_seen != 0 || bad_seen != 0) begin
      errors++;
      $display("FAIL halt_hold: req_cycles=%0d bad_cycles=%0d, expected 0 0", req_seen, bad_seen);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    logic [PC_W-1:0] addr;
    int n;
    do_reset();
    run_instr(9'h124, 8'h00, ok, addr);
    wait_req(ok, addr, n);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (!ok || {pc, imem_req, instr_valid, instr_immediate} !== {10'd0, 1'b0, 1'b0, 9'h000}) begin
      errors++;
      $display("FAIL async_reset: ok=%0d pc=%0d req=%b valid=%b instr=%h, expected all zero",
               ok, pc, imem_req, instr_valid, instr_immediate);
    end
    @(negedge CLK);
    reset_n     = 1'b1;
    imem_rdata  = 9'h10F;
    imem_rvalid = 1'b1;
    @(negedge CLK);
    imem_rvalid = 1'b0;
    checks++;
    if ({imem_req, imem_addr, instr_immediate, instr_valid} !== {1'b1, 10'd0, 9'h000, 1'b0}) begin
      errors++;
      $display("FAIL stale_rvalid: req=%b addr=%0d instr=%h valid=%b, expected 1 0 000 0",
               imem_req, imem_addr, instr_immediate, instr_valid);
    end
    mem_reply(9'h124, 1);
    checks++;
    if ({instr_valid, instr_immediate, halted} !== {1'b1, 9'h124, 1'b0}) begin
      errors++;
      $display("FAIL refetch: valid=%b instr=%h halted=%b, expected 1 124 0", instr_valid, instr_immediate, halted);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    imem_rdata  = 9'h000;
    imem_rvalid = 1'b0;
    ex_ready    = 1'b0;
    alu_out     = 8'h00;
    test_reset_fetch();
    test_stall();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
